cordic_pipe: RTL and testbench
==============================

Name: cordic_pipe

Overview:
- Parametrised, fully pipelined CORDIC engine for the SDR datapath (NCO mixing, polar conversion for AGC and demod).
- Supports two modes, selectable per sample:
  - Rotation: rotate (x,y) by an angle.
  - Vectoring: return magnitude·K and atan2(y,x).
- Valid/ready flow control with whole-pipeline stall, so it can sit between streaming blocks without external FIFOs.
- A user tag is carried alongside each sample.

Parameters:
- DATA_WIDTH, 16, signed input x/y width.
- ANGLE_WIDTH, 32, binary angle width; 2^ANGLE_WIDTH = 360°, two's complement, so MSB pair = quadrant.
- ITERATIONS, 16, number of micro-rotation stages; legal range 1..ANGLE_WIDTH-2.
- GUARD_BITS, 2, extra LSBs carried internally on x/y.
- TAG_WIDTH, 8, sideband tag width (≥1).

Ports:
- i_clk  in  1  clock.
- i_resetn  in  1  reset.
- i_valid  in  1  input sample valid.
- o_inReady  out  1  block can accept input this cycle.
- i_mode  in  1  0 = rotation, 1 = vectoring.
- i_xIn  in  DATA_WIDTH  signed x.
- i_yIn  in  DATA_WIDTH  signed y.
- i_angle  in  ANGLE_WIDTH  rotation angle; ignored in vectoring.
- i_tag  in  TAG_WIDTH  user tag.
- o_valid  out  1  output valid.
- i_outReady  in  1  downstream accepts output.
- o_xOut  out  DATA_WIDTH+2  signed x result.
- o_yOut  out  DATA_WIDTH+2  signed y result.
- o_zOut  out  ANGLE_WIDTH  residual angle (rotation) or atan2(y,x) (vectoring).
- o_tag  out  TAG_WIDTH  tag of the output sample.
- o_mode  out  1  mode of the output sample.

Behaviour:
- Reset: i_resetn, asynchronous, active-low; clock i_clk.
  - Reset clears all stage valid bits, data registers and outputs to 0.
  - After reset, o_valid = 0 and o_inReady = 1.
  - Reset mid-operation discards all in-flight samples; no output appears for them.
- Pipeline: pre-rotation stage, then ITERATIONS micro-rotation stages, then output register. Latency ITERATIONS+2 cycles from accept to o_valid when unstalled.
- Flow control:
  - en = i_outReady | ~o_valid; o_inReady = en (combinational).
  - When en = 1, every stage (valid, data, tag, mode) advances one step. Accept occurs when i_valid & en.
  - When en = 0, all stages hold. o_* stays stable while o_valid & ~i_outReady.
  - Bubbles propagate as valid = 0; they do not collapse.
  - Throughput: 1 sample/cycle when i_outReady = 1.
- Internal x/y width: W = DATA_WIDTH+2+GUARD_BITS. Input sign-extended and left-shifted by GUARD_BITS. Negation of the most-negative input must not overflow.
- Pre-rotation, rotation mode (by i_angle[MSB:MSB-1]):
  - 00/11: pass through; z = i_angle.
  - 01: (x,y) ← (−y,x); z = i_angle − quarter.
  - 10: (x,y) ← (y,−x); z = i_angle + quarter.
- Pre-rotation, vectoring mode:
  - x ≥ 0: pass through; z = 0.
  - x < 0, y ≥ 0: (x,y) ← (y,−x); z = +quarter.
  - x < 0, y < 0: (x,y) ← (−y,x); z = −quarter.
- Stage i direction select d:
  - Rotation: d = +1 if z ≥ 0, else −1.
  - Vectoring: d = +1 if y < 0, else −1.
- Stage i update:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
  - atan_i = round(atan(2^−i)·2^ANGLE_WIDTH/(2π)); table computed at elaboration from parameters.
- Angle arithmetic wraps modulo 2^ANGLE_WIDTH.
- Output:
  - o_xOut/o_yOut = internal value arithmetic-shifted right by GUARD_BITS (truncation toward −∞).
  - Gain K ≈ 1.64676 is not compensated.
  - o_zOut = final z register; o_tag and o_mode delayed with the sample.
- Mode may change every sample; no dead cycles between modes.

Test Plan (DATA_WIDTH=16, ANGLE_WIDTH=32, ITERATIONS=16, GUARD_BITS=2; x/y tolerance ±4 LSB, angle tolerance ±2^16):
- Rotation: x=10000, y=0, angle=0x40000000 (90°), tag=0x5A → after exactly 18 cycles o_valid=1, x≈0, y≈16468, z≈0, tag=0x5A.
- Rotation, all quadrants: x=10000, y=0 at angles 0x20000000/0x60000000/0xA0000000/0xE0000000 → (x,y)≈(11644,11644)/(−11644,11644)/(−11644,−11644)/(11644,−11644).
- Vectoring: (−10000,0) → x≈16468, z≈0x80000000. (0,−10000) → z≈0xC0000000. (−32768,−32768) → x≈76314, no overflow.
- Backpressure: 20 back-to-back samples, i_outReady toggled pseudo-randomly → all 20 outputs delivered in order with correct tags, none dropped or duplicated, o_* stable while stalled.
- Reset mid-stream: assert i_resetn=0 with 10 samples in flight → o_valid=0 immediately (async); after release no stale outputs, next sample appears after 18 cycles.
- Mode interleave: alternate rotation/vectoring every cycle → each output matches its own mode's expected value, and o_mode matches.

Source files
------------

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: per-sample rotation or vectoring mode,
// valid/ready flow control with a whole-pipeline stall and a tag sideband.
module cordic_pipe #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ANGLE_WIDTH = 32,
    parameter int unsigned ITERATIONS  = 16,
    parameter int unsigned GUARD_BITS  = 2,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic                    i_valid,
    output logic                    o_inReady,
    input  logic                    i_mode,
    input  logic [DATA_WIDTH-1:0]   i_xIn,
    input  logic [DATA_WIDTH-1:0]   i_yIn,
    input  logic [ANGLE_WIDTH-1:0]  i_angle,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    output logic                    o_valid,
    input  logic                    i_outReady,
    output logic [DATA_WIDTH+1:0]   o_xOut,
    output logic [DATA_WIDTH+1:0]   o_yOut,
    output logic [ANGLE_WIDTH-1:0]  o_zOut,
    output logic [TAG_WIDTH-1:0]    o_tag,
    output logic                    o_mode
);

    localparam int unsigned W  = DATA_WIDTH + 2 + GUARD_BITS;
    localparam int unsigned OW = DATA_WIDTH + 2;
    localparam int unsigned AW = ANGLE_WIDTH;
    localparam int unsigned N  = ITERATIONS;
    localparam logic [AW-1:0] QUARTER = {2'b01, {(AW-2){1'b0}}};

    // Elaboration-time arctangent table entry in binary-angle units
    function automatic logic [AW-1:0] atan_entry(input int unsigned i);
        real r;
        r = $atan(2.0 ** (-real'(i))) * (2.0 ** AW) / (2.0 * 3.14159265358979323846);
        return AW'(longint'(r));
    endfunction

    logic                en;
    logic signed [W-1:0] x_ext, y_ext;
    logic signed [W-1:0] pre_x, pre_y;
    logic [AW-1:0]       pre_z;

    logic signed [W-1:0]  x_q [0:N];
    logic signed [W-1:0]  y_q [0:N];
    logic [AW-1:0]        z_q [0:N];
    logic [TAG_WIDTH-1:0] t_q [0:N];
    logic [N:0]           v_q;
    logic [N:0]           m_q;

    logic signed [W-1:0]  x_d [1:N];
    logic signed [W-1:0]  y_d [1:N];
    logic [AW-1:0]        z_d [1:N];

    assign en        = i_outReady | ~o_valid;
    assign o_inReady = en;

    // Two extra integer bits keep the negation of the most-negative input in range
    assign x_ext = {{(W-DATA_WIDTH){i_xIn[DATA_WIDTH-1]}}, i_xIn} << GUARD_BITS;
    assign y_ext = {{(W-DATA_WIDTH){i_yIn[DATA_WIDTH-1]}}, i_yIn} << GUARD_BITS;

    // Coarse +/-90 degree pre-rotation into the CORDIC convergence range
    always_comb begin
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = i_angle;
        if (i_mode) begin
            pre_z = '0;
            if (x_ext[W-1]) begin
                if (!y_ext[W-1]) begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = QUARTER;
                end else begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = -QUARTER;
                end
            end
        end else begin
            case (i_angle[AW-1 -: 2])
                2'b01: begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = i_angle - QUARTER;
                end
                2'b10: begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = i_angle + QUARTER;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_stage
        localparam logic [AW-1:0] ATAN_I = atan_entry(i);
        logic                d_pos;
        logic signed [W-1:0] x_sh, y_sh;

        assign d_pos     = m_q[i] ? y_q[i][W-1] : ~z_q[i][AW-1];
        assign x_sh      = x_q[i] >>> i;
        assign y_sh      = y_q[i] >>> i;
        assign x_d[i+1]  = d_pos ? x_q[i] - y_sh : x_q[i] + y_sh;
        assign y_d[i+1]  = d_pos ? y_q[i] + x_sh : y_q[i] - x_sh;
        assign z_d[i+1]  = d_pos ? z_q[i] - ATAN_I : z_q[i] + ATAN_I;
    end

    // Whole pipeline advances together; bubbles travel as valid = 0
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            v_q <= '0;
            m_q <= '0;
            for (int unsigned k = 0; k <= N; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
                t_q[k] <= '0;
            end
            o_valid <= 1'b0;
            o_xOut  <= '0;
            o_yOut  <= '0;
            o_zOut  <= '0;
            o_tag   <= '0;
            o_mode  <= 1'b0;
        end else if (en) begin
            v_q    <= {v_q[N-1:0], i_valid};
            m_q    <= {m_q[N-1:0], i_mode};
            x_q[0] <= pre_x;
            y_q[0] <= pre_y;
            z_q[0] <= pre_z;
            t_q[0] <= i_tag;
            for (int unsigned k = 1; k <= N; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                z_q[k] <= z_d[k];
                t_q[k] <= t_q[k-1];
            end
            o_valid <= v_q[N];
            o_xOut  <= OW'(x_q[N] >>> GUARD_BITS);
            o_yOut  <= OW'(y_q[N] >>> GUARD_BITS);
            o_zOut  <= z_q[N];
            o_tag   <= t_q[N];
            o_mode  <= m_q[N];
        end
    end

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed bench for cordic_pipe: latency, quadrants, vectoring, mode
// interleave, random backpressure and asynchronous reset mid-stream.
module tb_cordic_pipe;

    logic        i_clk;
    logic        i_resetn;
    logic        i_valid;
    logic        o_inReady;
    logic        i_mode;
    logic [15:0] i_xIn;
    logic [15:0] i_yIn;
    logic [31:0] i_angle;
    logic [7:0]  i_tag;
    logic        o_valid;
    logic        i_outReady;
    logic [17:0] o_xOut;
    logic [17:0] o_yOut;
    logic [31:0] o_zOut;
    logic [7:0]  o_tag;
    logic        o_mode;

    cordic_pipe #(
        .DATA_WIDTH(16), .ANGLE_WIDTH(32), .ITERATIONS(16), .GUARD_BITS(2), .TAG_WIDTH(8)
    ) dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_valid(i_valid), .o_inReady(o_inReady),
        .i_mode(i_mode), .i_xIn(i_xIn), .i_yIn(i_yIn), .i_angle(i_angle), .i_tag(i_tag),
        .o_valid(o_valid), .i_outReady(i_outReady), .o_xOut(o_xOut), .o_yOut(o_yOut),
        .o_zOut(o_zOut), .o_tag(o_tag), .o_mode(o_mode)
    );

    // Hand-computed vectors; K(16) = 1.6467603, 10000*K/sqrt(2) = 11644
    bit          vm [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int          vx [10] = '{10000, 10000, 10000, 10000, 10000, -10000, 0, -32768, 10000, -32768};
    int          vy [10] = '{0, 0, 0, 0, 0, 0, -10000, -32768, 10000, -32768};
    logic [31:0] va [10] = '{32'h40000000, 32'h20000000, 32'h60000000, 32'hA0000000, 32'hE0000000,
                             32'h13572468, 32'h13572468, 32'h13572468, 32'h13572468, 32'h00000000};
    longint      ex [10] = '{0, 11644, -11644, -11644, 11644, 16468, 16468, 76314, 23289, -53961};
    longint      ey [10] = '{16468, 11644, 11644, -11644, -11644, 0, 0, 0, 0, -53961};
    longint      ez [10] = '{0, 0, 0, 0, 0, 64'h80000000, 64'hC0000000, 64'hA0000000, 64'h20000000, 0};
    int          order [10] = '{0, 5, 1, 6, 2, 7, 3, 8, 4, 9};

    typedef struct {
        bit          mode;
        longint      x, y, z, ty;
        logic [7:0]  tag;
    } exp_t;

    exp_t        q [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          bp_en    = 0;
    bit          stalled_prev = 0;
    logic [17:0] snap_x, snap_y;
    logic [31:0] snap_z;
    logic [7:0]  snap_t;
    logic        snap_m;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol, input bit wrap);
        longint      d;
        logic [31:0] d32;
        d = obs - exp;
        if (wrap) begin
            d32 = d[31:0];
            d   = longint'($signed(d32));
        end
        n_checks++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    task automatic drive_fields(input int idx, input logic [7:0] tag);
        i_mode  = vm[idx];
        i_xIn   = 16'(vx[idx]);
        i_yIn   = 16'(vy[idx]);
        i_angle = va[idx];
        i_tag   = tag;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] tag);
        exp_t e;
        e.mode = vm[idx];
        e.x    = ex[idx];
        e.y    = ey[idx];
        e.z    = ez[idx];
        e.ty   = vm[idx] ? 8 : 4;
        e.tag  = tag;
        q.push_back(e);
    endtask

    // Present one sample and hold it until accepted
    task automatic send(input int idx, input logic [7:0] tag);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        drive_fields(idx, tag);
        i_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge i_clk);
            acc = o_inReady;
            @(posedge i_clk);
            #1;
            n++;
        end
        check("send_acc", longint'(acc), 1, 0, 0);
        if (acc) push_exp(idx, tag);
        i_valid = 1'b0;
    endtask

    task automatic latency_run(input int idx, input logic [7:0] tag, input string name);
        int n;
        drive_fields(idx, tag);
        i_valid = 1'b1;
        @(negedge i_clk);
        check({name, "_inrdy"}, longint'(o_inReady), 1, 0, 0);
        push_exp(idx, tag);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 60) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check({name, "_lat"}, longint'(n), 18, 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("drain", longint'(q.size()), 0, 0, 0);
    endtask

    // Output scoreboard and stall-stability monitor
    always @(negedge i_clk) begin
        if (!i_resetn) begin
            stalled_prev = 0;
        end else begin
            if (stalled_prev) begin
                check("hold_x", longint'(o_xOut), longint'(snap_x), 0, 0);
                check("hold_y", longint'(o_yOut), longint'(snap_y), 0, 0);
                check("hold_z", longint'(o_zOut), longint'(snap_z), 0, 0);
                check("hold_tag", longint'(o_tag), longint'(snap_t), 0, 0);
                check("hold_valid", longint'(o_valid), 1, 0, 0);
                check("hold_mode", longint'(o_mode), longint'(snap_m), 0, 0);
            end
            if (o_valid && i_outReady) begin
                if (q.size() == 0) begin
                    check("spurious_out", longint'(o_valid), 0, 0, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("out_tag", longint'(o_tag), longint'(mon_e.tag), 0, 0);
                    check("out_mode", longint'(o_mode), longint'(mon_e.mode), 0, 0);
                    check("out_x", longint'($signed(o_xOut)), mon_e.x, 4, 0);
                    check("out_y", longint'($signed(o_yOut)), mon_e.y, mon_e.ty, 0);
                    check("out_z", longint'(o_zOut), mon_e.z, 65536, 1);
                end
            end
            stalled_prev = o_valid && !i_outReady;
            snap_x = o_xOut;
            snap_y = o_yOut;
            snap_z = o_zOut;
            snap_t = o_tag;
            snap_m = o_mode;
        end
    end

    // Downstream ready: always 1, or pseudo-random while backpressure is enabled
    initial begin
        i_outReady = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            i_outReady = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_resetn = 1'b0;
        i_valid  = 1'b0;
        i_mode   = 1'b0;
        i_xIn    = '0;
        i_yIn    = '0;
        i_angle  = '0;
        i_tag    = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", longint'(o_valid), 0, 0, 0);
        check("rst_inrdy", longint'(o_inReady), 1, 0, 0);
        check("rst_x", longint'(o_xOut), 0, 0, 0);
        check("rst_z", longint'(o_zOut), 0, 0, 0);
        check("rst_tag", longint'(o_tag), 0, 0, 0);
        i_resetn = 1'b1;
        @(posedge i_clk);
        #1;

        latency_run(0, 8'h5A, "lat0");
        drain();

        // Back-to-back, modes alternating
        for (int i = 0; i < 10; i++) send(order[i], 8'(8'h10 + i));
        drain();

        // Random backpressure, 20 samples
        bp_en = 1;
        for (int i = 0; i < 20; i++) send(order[i % 10], 8'(8'h80 + i));
        repeat (40) @(posedge i_clk);
        #1;
        bp_en = 0;
        drain();

        // Reset with samples in flight
        for (int i = 0; i < 10; i++) send(i, 8'(8'h40 + i));
        n = 0;
        while (!o_valid && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("rst_inflight", longint'(o_valid), 1, 0, 0);
        #1;
        i_resetn = 1'b0;
        #1;
        check("rst_async_valid", longint'(o_valid), 0, 0, 0);
        check("rst_async_tag", longint'(o_tag), 0, 0, 0);
        q.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_resetn = 1'b1;
        repeat (30) @(posedge i_clk);
        #1;
        check("rst_idle", longint'(o_valid), 0, 0, 0);
        latency_run(1, 8'hC3, "lat1");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
